// File: rtl/ftq_queue_param_pkg.sv
// Shared FTQ defaults, pointer-width helper and error-flag layout.
// Optional feature macro used by the top: FTQ_ERR_CHK_EN.
package ftq_queue_param_pkg;

    localparam int FTQ_WIDTH    = 24;
    localparam int FTQ_DEPTH    = 64;
    localparam int FTQ_AF_LEVEL = 56;

    // Pointer carries one extra wrap bit above the storage index.
    function automatic int ftq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic unf;  // bit 1: sticky underflow
        logic ovf;  // bit 0: sticky overflow
    } ftq_err_t;

endpackage

// File: rtl/ftq_queue_param_ram.sv
// FTQ storage: DEPTH x WIDTH, one synchronous write port, two async read ports.
module ftq_queue_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/ftq_queue_param.sv
// Fetch-target queue: wrap-bit pointer circular buffer with head/head+1 look-ahead and flush.
// Define FTQ_ERR_CHK_EN to build the sticky overflow/underflow detectors behind FifoErr.
module ftq_queue_param
    import ftq_queue_param_pkg::*;
#(
    parameter int WIDTH    = FTQ_WIDTH,
    parameter int DEPTH    = FTQ_DEPTH,
    parameter int AF_LEVEL = FTQ_AF_LEVEL,
    parameter int PW       = ftq_ptr_w(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             Wable,
    input  logic [WIDTH-1:0] Din,
    input  logic             Rable,
    output logic [WIDTH-1:0] FifoPreOut,
    output logic [WIDTH-1:0] FifoPreOut1,
    output logic [1:0]       FifoPreVld,
    input  logic             FifoClean,
    output logic             FifoFull,
    output logic             FifoEmpty,
    output logic             FifoAlmostFull,
    output logic [PW-1:0]    FifoCount,
    output logic [1:0]       FifoErr
);

    localparam int AW = PW - 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);

    logic [PW-1:0] wptr, rptr, rptr1, count;
    logic          push_acc, pop_acc, ram_we;

    // Flags depend only on registered pointers, never on Wable/Rable.
    assign count          = wptr - rptr;
    assign FifoEmpty      = (wptr == rptr);
    assign FifoFull       = (count == FULL_CNT);
    assign FifoAlmostFull = (count >= AF_CNT);
    assign FifoCount      = count;
    assign FifoPreVld     = {count >= PW'(2), !FifoEmpty};

    assign pop_acc  = Rable && !FifoEmpty;
    assign push_acc = Wable && (!FifoFull || pop_acc);
    assign ram_we   = push_acc && !Rest && !FifoClean;
    assign rptr1    = rptr + PW'(1);

    always_ff @(posedge Clk) begin
        if (Rest || FifoClean) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_acc) wptr <= wptr + PW'(1);
            if (pop_acc)  rptr <= rptr1;
        end
    end

    ftq_queue_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .Clk    (Clk),
        .we     (ram_we),
        .waddr  (wptr[AW-1:0]),
        .wdata  (Din),
        .raddr0 (rptr[AW-1:0]),
        .raddr1 (rptr1[AW-1:0]),
        .rdata0 (FifoPreOut),
        .rdata1 (FifoPreOut1)
    );

`ifdef FTQ_ERR_CHK_EN
    ftq_err_t err_q;
    logic     ovf_ev, unf_ev;

    assign ovf_ev = Wable && FifoFull && !pop_acc;
    assign unf_ev = Rable && FifoEmpty;

    // Sticky until reset; a flush leaves the history intact.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            err_q <= '0;
        end else begin
            if (ovf_ev) err_q.ovf <= 1'b1;
            if (unf_ev) err_q.unf <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge Clk) begin
        if (!Rest && ovf_ev) $error("ftq_queue_param: push while full");
        if (!Rest && unf_ev) $error("ftq_queue_param: pop while empty");
    end
`endif

    assign FifoErr = err_q;
`else
    assign FifoErr = 2'b00;
`endif

endmodule
